vlane_ctrl: RTL
===============

VLANE_CTRL -- requirements
Module: vlane_ctrl

Interface
REQ-001 Parameter ELEMS, default 4: elements held per lane per vector register, at least 2.
REQ-002 Parameter RD_LAT, default 2: VRF read latency in cycles, at least 1.
REQ-003 Parameter EXE_STAGES, default 1: execute pipeline depth, at least 1; L = RD_LAT + EXE_STAGES.
REQ-004 Derived constant EB = $clog2(ELEMS); VB = $clog2(ELEMS+1).
REQ-005 clk_i  in  1  clock, rising edge.
REQ-006 resetn_i  in  1  reset, asynchronous, active-low.
REQ-007 instr_valid_i  in  1  instruction offered.
REQ-008 instr_ready_o  out  1  controller can accept an instruction.
REQ-009 vl_i  in  VB  active element count for this lane.
REQ-010 vm_i  in  1  1 = unmasked, 0 = mask applies.
REQ-011 mask_i  in  ELEMS  per-element mask bits.
REQ-012 rd_en_o  out  1  VRF operand read strobe.
REQ-013 rd_elem_o  out  EB  element index being read.
REQ-014 wr_en_o  out  1  VRF write-back strobe.
REQ-015 wr_elem_o  out  EB  element index being written.
REQ-016 busy_o  out  1  controller not in IDLE.
REQ-017 done_o  out  1  one-cycle completion pulse.
REQ-018 busy_cycles_o  out  32  performance counter.

Function
REQ-019 Handshake: an instruction is accepted when instr_valid_i && instr_ready_o.
REQ-020 instr_ready_o SHALL be 1 only in IDLE.
REQ-021 On acceptance, vl_i, vm_i and mask_i SHALL be captured; vl_i greater than ELEMS saturates to ELEMS.
REQ-022 FSM states are IDLE, ISSUE, DRAIN, DONE.
REQ-023 IDLE transitions to ISSUE on accept with captured vl>0, and to DONE on accept with vl==0.
REQ-024 ISSUE: rd_en_o=1 every cycle; rd_elem_o steps 0..vl-1, one element per cycle; after element vl-1 the FSM goes to DRAIN.
REQ-025 Each read pushes a token {valid, elem} into an L-deep shift pipeline; a token emerges exactly L cycles after its read.
REQ-026 wr_en_o SHALL equal token valid && (vm || mask[elem]); wr_elem_o SHALL equal the token elem.
REQ-027 Writes overlap ISSUE; no bubble is inserted.
REQ-028 DRAIN goes to DONE in the cycle after the pipeline holds no valid token.
REQ-029 DONE asserts done_o for exactly one cycle, then goes to IDLE.
REQ-030 Timing: with acceptance at cycle 0, element k is read at cycle 1+k, written at cycle 1+k+L, and done_o occurs at cycle vl+L+1 (cycle 1 when vl==0).
REQ-031 Masked-off tokens SHALL still occupy their pipeline slot, so timing is independent of the mask.
REQ-032 Captured operands SHALL be unaffected by input changes while busy_o=1.
REQ-033 rd_elem_o and wr_elem_o SHALL be 0 whenever the corresponding enable is 0.

Reset
REQ-034 Asserting resetn_i at any time, including mid-instruction, SHALL force IDLE, clear all pipeline tokens and clear captured state.
REQ-035 During and after reset: instr_ready_o=1; rd_en_o, wr_en_o, busy_o and done_o = 0; elem outputs = 0; busy_cycles_o = 0.
REQ-036 No write strobe SHALL be produced for tokens in flight at reset.

Configuration
REQ-037 Macro VLANE_CTRL_PERF_EN defined: busy_cycles_o increments by 1 on every cycle with busy_o=1 and wraps modulo 2^32.
REQ-038 Macro VLANE_CTRL_PERF_EN undefined: busy_cycles_o is tied to 0, no counter flops exist, and the port remains present.

Structure
REQ-039 The state typedef vlane_state_t and the token struct vlane_tok_t SHALL live in vect_pkg.
REQ-040 The token shift pipeline SHALL be the sub-module vlane_pipe_tracker, parametrised by depth L and width EB; it outputs the emerging token and an any-valid flag.

Verification (ELEMS=4, RD_LAT=2, EXE_STAGES=1, so L=3; accept at cycle 0)
REQ-041 vl=4, vm=1 -> rd_en_o at cycles 1-4 with elems 0-3; wr_en_o at cycles 4-7 with elems 0-3; done_o at cycle 8.
REQ-042 vl=4, vm=0, mask=4'b0101 -> wr_en_o only at cycle 4 (elem 0) and cycle 6 (elem 2); done_o at cycle 8.
REQ-043 vl=0 -> no rd_en_o or wr_en_o; done_o at cycle 1; instr_ready_o=1 at cycle 2.
REQ-044 vl=7 -> saturates to 4; behaviour identical to REQ-041.
REQ-045 instr_valid_i held high across two instructions -> the second is accepted at cycle 9, and its first read occurs at cycle 10.
REQ-046 resetn_i low at cycle 5 of a vl=4 instruction -> wr_en_o stays 0 from then on, and all outputs match REQ-035; with the macro defined, busy_cycles_o reads 4 just before reset.

Source files
------------

// File: rtl/vect_pkg.sv
// Vector lane controller shared types.
// FSM state encoding and the write-back tracking token.
package vect_pkg;

  localparam int TOK_EW = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } vlane_state_t;

  typedef struct packed {
    logic              valid;
    logic [TOK_EW-1:0] elem;
  } vlane_tok_t;

endpackage

// File: rtl/vlane_ctrl_if.sv
// Vector lane controller instruction and VRF port bundle.
// master drives instructions, slave is the controller.
interface vlane_ctrl_if #(
  parameter int ELEMS = 4
) ();

  localparam int EB = $clog2(ELEMS);
  localparam int VB = $clog2(ELEMS + 1);

  logic             instr_valid_i;
  logic             instr_ready_o;
  logic [VB-1:0]    vl_i;
  logic             vm_i;
  logic [ELEMS-1:0] mask_i;
  logic             rd_en_o;
  logic [EB-1:0]    rd_elem_o;
  logic             wr_en_o;
  logic [EB-1:0]    wr_elem_o;
  logic             busy_o;
  logic             done_o;
  logic [31:0]      busy_cycles_o;

  modport master (
    output instr_valid_i, vl_i, vm_i, mask_i,
    input  instr_ready_o, rd_en_o, rd_elem_o,
    input  wr_en_o, wr_elem_o, busy_o, done_o,
    input  busy_cycles_o
  );

  modport slave (
    input  instr_valid_i, vl_i, vm_i, mask_i,
    output instr_ready_o, rd_en_o, rd_elem_o,
    output wr_en_o, wr_elem_o, busy_o, done_o,
    output busy_cycles_o
  );

endinterface

// File: rtl/vlane_pipe_tracker.sv
// L-deep token shift pipeline mirroring read-to-write latency.
// any_valid_o flags tokens still upstream of the output slot.
module vlane_pipe_tracker
  import vect_pkg::*;
#(
  parameter int L = 3,
  parameter int W = 2
) (
  input  logic       clk_i,
  input  logic       resetn_i,
  input  vlane_tok_t in_tok_i,
  output vlane_tok_t out_tok_o,
  output logic       any_valid_o
);

  localparam logic [L-1:0] LAST = L'(1) << (L - 1);

  logic [L-1:0] vld_q;
  logic [W-1:0] elem_q [L];
  logic         unused_tok;

  assign unused_tok = ^in_tok_i.elem;

  // shift tokens one slot per cycle
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      vld_q <= '0;
      for (int i = 0; i < L; i++) begin
        elem_q[i] <= '0;
      end
    end else begin
      vld_q[0]  <= in_tok_i.valid;
      elem_q[0] <= in_tok_i.valid ? in_tok_i.elem[W-1:0] : '0;
      for (int i = 1; i < L; i++) begin
        vld_q[i]  <= vld_q[i-1];
        elem_q[i] <= elem_q[i-1];
      end
    end
  end

  // present the emerging token
  always_comb begin
    out_tok_o       = '0;
    out_tok_o.valid = vld_q[L-1];
    out_tok_o.elem  = TOK_EW'(elem_q[L-1]);
  end

  assign any_valid_o = |(vld_q & ~LAST);

endmodule

// File: rtl/vlane_ctrl.sv
// Vector lane issue/write-back sequencer.
// VLANE_CTRL_PERF_EN enables the busy-cycle counter.
module vlane_ctrl
  import vect_pkg::*;
#(
  parameter int ELEMS      = 4,
  parameter int RD_LAT     = 2,
  parameter int EXE_STAGES = 1
) (
  input logic         clk_i,
  input logic         resetn_i,
  vlane_ctrl_if.slave bus
);

  localparam int L  = RD_LAT + EXE_STAGES;
  localparam int EB = $clog2(ELEMS);
  localparam int VB = $clog2(ELEMS + 1);

  vlane_state_t     state_q, state_d;
  logic [EB-1:0]    cnt_q, cnt_d;
  logic [VB-1:0]    vl_q, vl_sat;
  logic             vm_q;
  logic [ELEMS-1:0] mask_q;
  logic             accept, last, rd_en;
  logic             any_valid, wr_en;
  logic [EB-1:0]    tok_elem;
  vlane_tok_t       in_tok, out_tok;
  logic             unused_tok;

  assign vl_sat = (bus.vl_i > VB'(ELEMS)) ? VB'(ELEMS) : bus.vl_i;
  assign accept = bus.instr_valid_i && (state_q == IDLE);
  assign last   = (VB'(cnt_q) == vl_q - VB'(1));

  // state and element counter
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // operand capture, frozen while busy
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      vl_q   <= '0;
      vm_q   <= 1'b0;
      mask_q <= '0;
    end else if (accept) begin
      vl_q   <= vl_sat;
      vm_q   <= bus.vm_i;
      mask_q <= bus.mask_i;
    end
  end

  // next state and read issue
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d   = '0;
          state_d = (vl_sat == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        rd_en = 1'b1;
        if (last) begin
          cnt_d   = '0;
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q + EB'(1);
        end
      end
      DRAIN: begin
        if (!any_valid) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // token for the element being read
  always_comb begin
    in_tok       = '0;
    in_tok.valid = rd_en;
    in_tok.elem  = rd_en ? TOK_EW'(cnt_q) : '0;
  end

  vlane_pipe_tracker #(
    .L (L),
    .W (EB)
  ) u_trk (
    .clk_i       (clk_i),
    .resetn_i    (resetn_i),
    .in_tok_i    (in_tok),
    .out_tok_o   (out_tok),
    .any_valid_o (any_valid)
  );

  assign tok_elem   = out_tok.elem[EB-1:0];
  assign unused_tok = ^out_tok.elem;
  assign wr_en      = out_tok.valid &&
                      (vm_q || mask_q[tok_elem]);

  assign bus.instr_ready_o = (state_q == IDLE);
  assign bus.busy_o        = (state_q != IDLE);
  assign bus.done_o        = (state_q == DONE);
  assign bus.rd_en_o       = rd_en;
  assign bus.rd_elem_o     = rd_en ? cnt_q : '0;
  assign bus.wr_en_o       = wr_en;
  assign bus.wr_elem_o     = wr_en ? tok_elem : '0;

`ifdef VLANE_CTRL_PERF_EN
  logic [31:0] perf_q;

  // count busy cycles, wrapping naturally
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      perf_q <= '0;
    end else if (state_q != IDLE) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign bus.busy_cycles_o = perf_q;
`else
  assign bus.busy_cycles_o = '0;
`endif

endmodule
